nanosoc_axi_stream_io_8_arbiter: RTL and testbench
==================================================

# nanosoc_axi_stream_io_8_arbiter

Round-robin arbiter that merges NUM_SRC independent 8-bit AXI-stream byte sources (per-core or per-subsystem UART/ADP trace streams) onto the single 8-bit stream feeding the testbench byte-logging sink. Grants are line-granular: a granted source keeps the output until it sends the end-of-line character, sends end-of-transmission, or stalls past a timeout, so log lines from different sources never interleave. A per-source 0x04 end-of-transmission is absorbed; one 0x04 is forwarded downstream only after every source has finished, which terminates the sink.

## Interface
- NUM_SRC, 4: number of sources, legal 2..8.
- EOL_CHAR, 8'h0A: byte that ends a line and releases the grant.
- EOT_CHAR, 8'h04: per-source end-of-transmission byte.
- IDLE_TIMEOUT, 32: stall cycles with the grant held before forced release; 0 disables the timeout.
- aclk  in  1  single clock, all logic rising-edge.
- aresetn  in  1  reset, synchronous, active-low.
- src_valid  in  NUM_SRC  per-source valid.
- src_data  in  8*NUM_SRC  source i byte in bits [8i+7:8i].
- src_ready  out  NUM_SRC  per-source ready.
- out_valid  out  1  merged stream valid.
- out_data  out  8  merged stream byte.
- out_ready  in  1  sink ready.
- grant_id  out  3  index of current/last granted source.
- done_mask  out  NUM_SRC  bit i set once source i has sent EOT_CHAR.

## Operation
- States: IDLE, GRANT, EOT, DONE.
- IDLE: if any src_valid[i] with done_mask[i]=0, choose the first such i searching upward from rr_ptr with wrap; register grant_id=i, go GRANT. Nothing is accepted in IDLE (one arbitration cycle).
- GRANT: src_ready[grant_id] = 1 when the output register is empty or out_ready=1; all other src_ready = 0. Transfer = src_valid & src_ready on the granted source.
  - Transfer of EOL_CHAR: byte forwarded; rr_ptr = grant_id+1 (mod NUM_SRC); go IDLE.
  - Transfer of EOT_CHAR: byte dropped (not forwarded); done_mask[grant_id] set; rr_ptr advanced; go EOT if all done_mask bits are now set, else IDLE.
  - Other bytes: forwarded; stay.
  - Stall counter: cleared on every transfer and on entry; increments each GRANT cycle without a transfer; reaching IDLE_TIMEOUT releases the grant (rr_ptr advanced, go IDLE).
- EOT: when the output register is empty or being emptied, load EOT_CHAR; go DONE.
- DONE: all src_ready 0; output drains the final byte; remains in DONE until reset.
- A done source is never granted again; its src_ready stays 0.

## Timing
- Reset values: out_valid 0, out_data 8'h00, src_ready all 0, grant_id 0, done_mask 0, rr_ptr 0, state IDLE, stall counter 0.
- Output is a one-entry register: accepted byte appears on out_data with out_valid the cycle after the transfer (latency 1). out_valid/out_data stable while out_ready=0.
- Full throughput: one byte per cycle within a granted line when out_ready stays 1.
- src_ready is a function of registered state and out_ready only; never depends on src_valid.
- Grant switch costs exactly one idle cycle (IDLE) on the output between lines.
- EOL or EOT transfer on the same cycle the stall counter would expire: the transfer wins; no timeout.
- Sink stalls (out_ready=0) do not count toward the timeout (no ready offered means it is not a source stall); counter holds.
- Reset asserted mid-line or with a byte in the output register: register and all state cleared on that edge; the pending byte is discarded.
- Stall counter width clog2(IDLE_TIMEOUT+1), saturating.

## Structure
- Shared package nanosoc_axi_stream_io_pkg: EOL/EOT default constants and the state enum encoding.
- One natural sub-module: nanosoc_rr_pick (combinational first-set-bit search from a rotating pointer, NUM_SRC-wide request → index + found flag). Output register, FSM, counter live in the top.

## Test plan
- Single source 0 sends "AB\n" with out_ready=1 → out_data 0x41,0x42,0x0A on three consecutive cycles after 1 IDLE + 1 latency cycle; grant_id=0.
- Sources 0 and 2 both valid with lines "x\n"/"y\n" → output "x\n", one gap cycle, "y\n"; then rr_ptr=3 so source 2 re-requesting loses to source 3 if both request.
- Source 1 sends "ab" then holds valid=0 with IDLE_TIMEOUT=4, source 3 waiting → grant released after 4 stall cycles, source 3 granted; source 1 later resumes its line.
- out_ready=0 for 10 cycles mid-line → out_data held, src_ready 0, no timeout release.
- All NUM_SRC sources send 0x04 in turn → no 0x04 appears until the last; then exactly one 0x04 output, done_mask all-ones, state DONE, all src_ready 0.
- Assert aresetn=0 for one cycle with out_valid=1 mid-line → next cycle out_valid 0, done_mask 0, grant restarts from source 0.

Source files
------------

// File: rtl/nanosoc_axi_stream_io_pkg.sv
// Shared definitions for the nanosoc AXI-stream byte arbiter.
//   EolCharDefault / EotCharDefault : default line and end-of-transmission bytes
//   arb_state_e                     : arbiter FSM state encoding
package nanosoc_axi_stream_io_pkg;

    localparam logic [7:0] EolCharDefault = 8'h0A;
    localparam logic [7:0] EotCharDefault = 8'h04;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StEot   = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/nanosoc_axi_stream_io_8_arbiter_if.sv
// Handshake bundle between NUM_SRC byte sources, the arbiter and the merged sink.
//   src_valid/src_data/src_ready : per-source streams, source i byte in src_data[8i+7:8i]
//   out_valid/out_data/out_ready : merged 8-bit stream
//   grant_id / done_mask         : current/last granted source, sources finished with EOT
// master: arbiter side. slave: environment side (sources + sink).
interface nanosoc_axi_stream_io_8_arbiter_if #(
    parameter int unsigned NUM_SRC = 4
) ();

    logic [NUM_SRC-1:0]   src_valid;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 out_valid;
    logic [7:0]           out_data;
    logic                 out_ready;
    logic [2:0]           grant_id;
    logic [NUM_SRC-1:0]   done_mask;

    modport master (
        input  src_valid, src_data, out_ready,
        output src_ready, out_valid, out_data, grant_id, done_mask
    );

    modport slave (
        output src_valid, src_data, out_ready,
        input  src_ready, out_valid, out_data, grant_id, done_mask
    );

endinterface

// File: rtl/nanosoc_rr_pick.sv
// Combinational round-robin pick: first set bit of req_i searching upward from ptr_i
// with wrap-around.
//   req_i   : request vector
//   ptr_i   : search start index (must be < NUM_SRC)
//   idx_o   : chosen index (0 when nothing found)
//   found_o : at least one request set
module nanosoc_rr_pick #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [2:0]         idx_o,
    output logic               found_o
);

    always_comb begin : p_pick
        int cand;
        cand    = 0;
        idx_o   = '0;
        found_o = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit is the last write.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= int'(NUM_SRC)) begin
                cand = cand - int'(NUM_SRC);
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                if (j == cand && req_i[j]) begin
                    idx_o   = 3'(j);
                    found_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nanosoc_axi_stream_io_8_arbiter.sv
// Line-granular round-robin arbiter merging NUM_SRC byte streams onto one stream.
// A grant is held until EOL_CHAR, EOT_CHAR or IDLE_TIMEOUT source-stall cycles.
// Per-source EOT bytes are absorbed; a single EOT_CHAR is emitted once all are done.
//   aclk, aresetn : clock, synchronous active-low reset
//   bus_io        : source/sink handshakes plus grant_id and done_mask status
module nanosoc_axi_stream_io_8_arbiter
    import nanosoc_axi_stream_io_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter logic [7:0]  EOL_CHAR     = EolCharDefault,
    parameter logic [7:0]  EOT_CHAR     = EotCharDefault,
    parameter int unsigned IDLE_TIMEOUT = 32
) (
    input logic                                aclk,
    input logic                                aresetn,
    nanosoc_axi_stream_io_8_arbiter_if.master  bus_io
);

    localparam int unsigned   CntW   = (IDLE_TIMEOUT == 0) ? 1 : $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = '1;

    arb_state_e         state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         rr_q, rr_d;
    logic [NUM_SRC-1:0] done_q, done_d;
    logic [CntW-1:0]    stall_q, stall_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;

    logic               out_space;
    logic               sel_valid;
    logic [7:0]         sel_data;
    logic [NUM_SRC-1:0] grant_oh;
    logic [NUM_SRC-1:0] src_ready;
    logic               xfer;
    logic               timeout_hit;
    logic [2:0]         rr_next;
    logic [2:0]         pick_idx;
    logic               pick_found;

    nanosoc_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req_i   (bus_io.src_valid & ~done_q),
        .ptr_i   (rr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Output register can take a byte if empty or being drained this cycle.
    assign out_space = !out_valid_q || bus_io.out_ready;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                sel_valid   = bus_io.src_valid[i];
                sel_data    = bus_io.src_data[8*i +: 8];
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Ready depends only on registered state and out_ready, never on src_valid.
    assign src_ready   = (state_q == StGrant && out_space) ? grant_oh : '0;
    assign xfer        = (state_q == StGrant) && out_space && sel_valid;
    assign rr_next     = (32'(grant_q) + 32'd1 >= NUM_SRC) ? 3'd0 : grant_q + 3'd1;
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (32'(stall_q) + 32'd1 >= IDLE_TIMEOUT);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        done_d      = done_q;
        stall_d     = stall_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (bus_io.out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    stall_d = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (xfer) begin
                    stall_d = '0;
                    if (sel_data == EOT_CHAR) begin
                        done_d  = done_q | grant_oh;
                        rr_d    = rr_next;
                        state_d = (&done_d) ? StEot : StIdle;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = sel_data;
                        if (sel_data == EOL_CHAR) begin
                            rr_d    = rr_next;
                            state_d = StIdle;
                        end
                    end
                end else if (out_space) begin
                    // Only cycles where ready was offered count as source stalls.
                    if (timeout_hit) begin
                        rr_d    = rr_next;
                        stall_d = '0;
                        state_d = StIdle;
                    end else if (stall_q != CntMax) begin
                        stall_d = stall_q + CntW'(1);
                    end
                end
            end
            StEot: begin
                if (out_space) begin
                    out_valid_d = 1'b1;
                    out_data_d  = EOT_CHAR;
                    state_d     = StDone;
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= '0;
            done_q      <= '0;
            stall_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            done_q      <= done_d;
            stall_q     <= stall_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus_io.src_ready = src_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.grant_id  = grant_q;
    assign bus_io.done_mask = done_q;

endmodule

// File: tb/tb_nanosoc_axi_stream_io_8_arbiter.sv
// Directed, table-driven bench for the 4-source arbiter (IDLE_TIMEOUT = 4).
// Each table row gives the inputs for one cycle and the outputs expected during
// that cycle (registered outputs from earlier edges, src_ready from current state).
module tb_nanosoc_axi_stream_io_8_arbiter;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ready;
        logic        ov;
        logic [7:0]  od;
        logic [3:0]  rdy;
        logic [2:0]  gid;
        logic [3:0]  done;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    nanosoc_axi_stream_io_8_arbiter_if #(.NUM_SRC(4)) bus ();

    nanosoc_axi_stream_io_8_arbiter #(
        .NUM_SRC      (4),
        .EOL_CHAR     (8'h0A),
        .EOT_CHAR     (8'h04),
        .IDLE_TIMEOUT (4)
    ) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .bus_io  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic r, input logic [3:0] v, input logic [31:0] d,
                                input logic rd, input logic ov, input logic [7:0] od,
                                input logic [3:0] rdy, input logic [2:0] gid,
                                input logic [3:0] done);
        vec_t e;
        e.rst_n = r; e.valid = v; e.data = d; e.ready = rd;
        e.ov = ov; e.od = od; e.rdy = rdy; e.gid = gid; e.done = done;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] d);
        @(negedge clk);
        bus.src_valid = v;
        bus.src_data  = d;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.out_ready = 1'b1;

        // Source 0 line "AB\n"
        add(1, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 0, 4'h0);
        add(1, 4'h1, 32'h41,       1, 0, 8'h00, 4'h0, 0, 4'h0);
        add(1, 4'h1, 32'h41,       1, 0, 8'h00, 4'h1, 0, 4'h0);
        add(1, 4'h1, 32'h42,       1, 1, 8'h41, 4'h1, 0, 4'h0);
        add(1, 4'h1, 32'h0A,       1, 1, 8'h42, 4'h1, 0, 4'h0);
        add(1, 4'h0, 32'h0,        1, 1, 8'h0A, 4'h0, 0, 4'h0);
        add(1, 4'h0, 32'h0,        1, 0, 8'h0A, 4'h0, 0, 4'h0);
        add(0, 4'h0, 32'h0,        1, 0, 8'h0A, 4'h0, 0, 4'h0);
        // Sources 0 and 2: "x\n" then gap then "y\n"; then 3 beats 2 from rr_ptr=3
        add(1, 4'h5, 32'h00790078, 1, 0, 8'h00, 4'h0, 0, 4'h0);
        add(1, 4'h5, 32'h00790078, 1, 0, 8'h00, 4'h1, 0, 4'h0);
        add(1, 4'h5, 32'h0079000A, 1, 1, 8'h78, 4'h1, 0, 4'h0);
        add(1, 4'h4, 32'h00790000, 1, 1, 8'h0A, 4'h0, 0, 4'h0);
        add(1, 4'h4, 32'h00790000, 1, 0, 8'h0A, 4'h4, 2, 4'h0);
        add(1, 4'h4, 32'h000A0000, 1, 1, 8'h79, 4'h4, 2, 4'h0);
        add(1, 4'hC, 32'h7A710000, 1, 1, 8'h0A, 4'h0, 2, 4'h0);
        add(1, 4'hC, 32'h7A710000, 1, 0, 8'h0A, 4'h8, 3, 4'h0);
        add(1, 4'hC, 32'h0A710000, 1, 1, 8'h7A, 4'h8, 3, 4'h0);
        add(1, 4'h0, 32'h0,        1, 1, 8'h0A, 4'h0, 3, 4'h0);
        // Source 1 "ab" then stalls; released after 4 stall cycles, source 3 runs
        add(1, 4'hA, 32'h77006100, 1, 0, 8'h0A, 4'h0, 3, 4'h0);
        add(1, 4'hA, 32'h77006100, 1, 0, 8'h0A, 4'h2, 1, 4'h0);
        add(1, 4'hA, 32'h77006200, 1, 1, 8'h61, 4'h2, 1, 4'h0);
        add(1, 4'h8, 32'h77000000, 1, 1, 8'h62, 4'h2, 1, 4'h0);
        for (int i = 0; i < 3; i++) begin
            add(1, 4'h8, 32'h77000000, 1, 0, 8'h62, 4'h2, 1, 4'h0);
        end
        add(1, 4'h8, 32'h77000000, 1, 0, 8'h62, 4'h0, 1, 4'h0);
        add(1, 4'h8, 32'h77000000, 1, 0, 8'h62, 4'h8, 3, 4'h0);
        add(1, 4'h8, 32'h0A000000, 1, 1, 8'h77, 4'h8, 3, 4'h0);
        // Source 1 resumes its line
        add(1, 4'h2, 32'h00006300, 1, 1, 8'h0A, 4'h0, 3, 4'h0);
        add(1, 4'h2, 32'h00006300, 1, 0, 8'h0A, 4'h2, 1, 4'h0);
        add(1, 4'h2, 32'h00000A00, 1, 1, 8'h63, 4'h2, 1, 4'h0);
        add(1, 4'h0, 32'h0,        1, 1, 8'h0A, 4'h0, 1, 4'h0);
        // Sink stall for 10 cycles mid-line on source 2
        add(1, 4'h4, 32'h006D0000, 1, 0, 8'h0A, 4'h0, 1, 4'h0);
        add(1, 4'h4, 32'h006D0000, 1, 0, 8'h0A, 4'h4, 2, 4'h0);
        add(1, 4'h4, 32'h006E0000, 1, 1, 8'h6D, 4'h4, 2, 4'h0);
        for (int i = 0; i < 10; i++) begin
            add(1, 4'h4, 32'h006F0000, 0, 1, 8'h6E, 4'h0, 2, 4'h0);
        end
        add(1, 4'h4, 32'h006F0000, 1, 1, 8'h6E, 4'h4, 2, 4'h0);
        add(1, 4'h4, 32'h000A0000, 1, 1, 8'h6F, 4'h4, 2, 4'h0);
        add(1, 4'h0, 32'h0,        1, 1, 8'h0A, 4'h0, 2, 4'h0);
        // Every source sends EOT in turn; only one EOT reaches the sink
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h0, 2, 4'h0);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h8, 3, 4'h0);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h0, 3, 4'h8);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h1, 0, 4'h8);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h0, 0, 4'h9);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h2, 1, 4'h9);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h0, 1, 4'hB);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h4, 2, 4'hB);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h0A, 4'h0, 2, 4'hF);
        add(1, 4'hF, 32'h04040404, 1, 1, 8'h04, 4'h0, 2, 4'hF);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h04, 4'h0, 2, 4'hF);
        add(1, 4'hF, 32'h04040404, 1, 0, 8'h04, 4'h0, 2, 4'hF);
        add(0, 4'h0, 32'h0,        1, 0, 8'h04, 4'h0, 2, 4'hF);
        // Reset with a byte pending mid-line on source 1
        add(1, 4'h2, 32'h00007200, 1, 0, 8'h00, 4'h0, 0, 4'h0);
        add(1, 4'h2, 32'h00007200, 1, 0, 8'h00, 4'h2, 1, 4'h0);
        add(1, 4'h2, 32'h00007300, 1, 1, 8'h72, 4'h2, 1, 4'h0);
        add(0, 4'h2, 32'h00007400, 1, 1, 8'h73, 4'h2, 1, 4'h0);
        add(1, 4'h5, 32'h00760075, 1, 0, 8'h00, 4'h0, 0, 4'h0);
        add(1, 4'h5, 32'h00760075, 1, 0, 8'h00, 4'h1, 0, 4'h0);
        add(1, 4'h0, 32'h0,        1, 1, 8'h75, 4'h1, 0, 4'h0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            bus.src_valid = vecs[i].valid;
            bus.src_data  = vecs[i].data;
            bus.out_ready = vecs[i].ready;
            #1;
            check($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            check($sformatf("row%0d out_data", i),  32'(bus.out_data),  32'(vecs[i].od));
            check($sformatf("row%0d src_ready", i), 32'(bus.src_ready), 32'(vecs[i].rdy));
            check($sformatf("row%0d grant_id", i),  32'(bus.grant_id),  32'(vecs[i].gid));
            check($sformatf("row%0d done_mask", i), 32'(bus.done_mask), 32'(vecs[i].done));
        end

        // EOL arriving on the cycle the stall counter would expire: the transfer wins.
        // Source 0 is granted with one stall cycle already counted.
        step(4'h0, 32'h0);
        check("expiry out_valid drained", 32'(bus.out_valid), 32'h0);
        check("expiry grant held 1", 32'(bus.src_ready), 32'h1);
        step(4'h0, 32'h0);
        check("expiry grant held 2", 32'(bus.src_ready), 32'h1);
        step(4'h1, 32'h0000000A);
        check("expiry grant held 3", 32'(bus.src_ready), 32'h1);
        step(4'h0, 32'h0);
        check("expiry eol out_valid", 32'(bus.out_valid), 32'h1);
        check("expiry eol out_data", 32'(bus.out_data), 32'h0A);
        check("expiry released", 32'(bus.src_ready), 32'h0);
        step(4'h0, 32'h0);
        check("expiry eol drained", 32'(bus.out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
